// File: rtl/sort_pkg.sv
// sort_pkg: AXI write-channel constants and state type shared by the sort
// engine's fetch and store paths.
package sort_pkg;

  localparam logic [2:0] SIZE_128B  = 3'd7;
  localparam logic [1:0] BURST_INCR = 2'd1;
  localparam logic [3:0] CACHE_NB   = 4'd3;
  localparam logic [1:0] RESP_OKAY  = 2'b00;
  localparam int         BEAT_BYTES = 128;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_RUN,
    ST_DONE
  } store_state_t;

endpackage

// File: rtl/sort_store_if.sv
// sort_store_if: AXI4 write address / data / response channels.
//   master modport: drives aw*, w*, bready; samples awready, wready, b*.
//   slave modport : the host-memory side of the same signals.
interface sort_store_if #(
  parameter int ID_WIDTH     = 1,
  parameter int AWUSER_WIDTH = 9,
  parameter int DATA_WIDTH   = 1024,
  parameter int ADDR_WIDTH   = 64
);

  logic [ID_WIDTH-1:0]     awid;
  logic [ADDR_WIDTH-1:0]   awaddr;
  logic [7:0]              awlen;
  logic [2:0]              awsize;
  logic [1:0]              awburst;
  logic [AWUSER_WIDTH-1:0] awuser;
  logic [3:0]              awcache;
  logic [1:0]              awlock;
  logic [2:0]              awprot;
  logic [3:0]              awqos;
  logic [3:0]              awregion;
  logic                    awvalid;
  logic                    awready;

  logic [DATA_WIDTH-1:0]   wdata;
  logic [DATA_WIDTH/8-1:0] wstrb;
  logic                    wlast;
  logic                    wvalid;
  logic                    wready;

  logic [ID_WIDTH-1:0]     bid;
  logic [1:0]              bresp;
  logic                    bvalid;
  logic                    bready;

  modport master (
    output awid, awaddr, awlen, awsize, awburst, awuser, awcache, awlock,
           awprot, awqos, awregion, awvalid,
    input  awready,
    output wdata, wstrb, wlast, wvalid,
    input  wready,
    input  bid, bresp, bvalid,
    output bready
  );

  modport slave (
    input  awid, awaddr, awlen, awsize, awburst, awuser, awcache, awlock,
           awprot, awqos, awregion, awvalid,
    output awready,
    input  wdata, wstrb, wlast, wvalid,
    output wready,
    output bid, bresp, bvalid,
    input  bready
  );

endinterface

// File: rtl/sort_store_beat_sel.sv
// sort_store_beat_sel: picks the 1024-bit write beat out of the latched
// result vector. Beat w_cnt of a beat_num-beat job is slice
// (beat_num-1-w_cnt), so the most significant populated slice leaves first.
//   store_data : latched result vector
//   beat_num   : latched (clamped) beat count
//   w_cnt      : beats already accepted on W
//   wdata      : selected slice
module sort_store_beat_sel #(
  parameter int DATA_WIDTH  = 1024,
  parameter int STORE_WIDTH = 32768
) (
  input  logic [STORE_WIDTH-1:0] store_data,
  input  logic [5:0]             beat_num,
  input  logic [5:0]             w_cnt,
  output logic [DATA_WIDTH-1:0]  wdata
);

  localparam int MAX_BEATS = STORE_WIDTH / DATA_WIDTH;
  localparam int SEL_W     = (MAX_BEATS > 1) ? $clog2(MAX_BEATS) : 1;

  logic [DATA_WIDTH-1:0] beats [MAX_BEATS];
  logic [SEL_W-1:0]      sel;

  for (genvar i = 0; i < MAX_BEATS; i++) begin : g_slice
    assign beats[i] = store_data[i*DATA_WIDTH +: DATA_WIDTH];
  end

  // Only meaningful while w_cnt < beat_num; wvalid is low otherwise.
  assign sel   = SEL_W'(beat_num - 6'd1 - w_cnt);
  assign wdata = beats[sel];

endmodule

// File: rtl/sort_store.sv
// sort_store: AXI4 write master for the sort engine result. A start pulse
// latches the result vector and writes it as single-beat 128-byte writes at
// consecutive addresses; store_done goes high once every response is back,
// store_err is sticky on any non-OKAY response.
//   clk, rst          : clock, synchronous active-high reset
//   store_start       : one-cycle start (ignored while running)
//   store_start_addr  : 128-byte aligned address of beat 0
//   store_pasid       : driven on awuser
//   store_data        : result vector, sampled on start
//   store_beat_num    : beats to write (0..32, clamped), sampled on start
//   store_done        : level, high in DONE
//   store_err         : sticky response error
//   m_axi             : AXI write channels (master side)
module sort_store
  import sort_pkg::*;
#(
  parameter int ID_WIDTH     = 1,
  parameter int AWUSER_WIDTH = 9,
  parameter int PASID_WIDTH  = 9,
  parameter int STORE_WIDTH  = 32768,
  parameter int DATA_WIDTH   = 1024,
  parameter int ADDR_WIDTH   = 64
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   store_start,
  input  logic [ADDR_WIDTH-1:0]  store_start_addr,
  input  logic [PASID_WIDTH-1:0] store_pasid,
  input  logic [STORE_WIDTH-1:0] store_data,
  input  logic [5:0]             store_beat_num,
  output logic                   store_done,
  output logic                   store_err,
  sort_store_if.master           m_axi
);

  localparam logic [5:0] MAX_BEATS = 6'(STORE_WIDTH / DATA_WIDTH);

  store_state_t state, state_nxt;

  logic [ADDR_WIDTH-1:0]  base_q;
  logic [PASID_WIDTH-1:0] pasid_q;
  logic [STORE_WIDTH-1:0] data_q;
  logic [5:0]             beats_q;
  logic [5:0]             aw_cnt, w_cnt, b_cnt;
  logic [5:0]             beats_clamped;
  logic [DATA_WIDTH-1:0]  wdata_sel;
  logic                   start_ok, aw_hs, w_hs, b_hit, last_b;
  logic                   unused_bid;

  assign beats_clamped = (store_beat_num > MAX_BEATS) ? MAX_BEATS : store_beat_num;
  assign start_ok      = store_start && (state != ST_RUN);
  assign aw_hs         = m_axi.awvalid && m_axi.awready;
  assign w_hs          = m_axi.wvalid && m_axi.wready;
  assign b_hit         = (state == ST_RUN) && m_axi.bvalid;
  // Counts the response arriving this cycle so DONE is reached without a bubble.
  assign last_b        = (b_cnt + 6'(b_hit)) >= beats_q;
  assign unused_bid    = ^m_axi.bid;

  always_ff @(posedge clk) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt     = state;
    m_axi.awvalid = 1'b0;
    m_axi.wvalid  = 1'b0;
    store_done    = 1'b0;
    case (state)
      ST_IDLE: begin
        if (store_start) state_nxt = (beats_clamped == 6'd0) ? ST_DONE : ST_RUN;
      end
      ST_RUN: begin
        m_axi.awvalid = aw_cnt < beats_q;
        m_axi.wvalid  = w_cnt < beats_q;
        if (last_b) state_nxt = ST_DONE;
      end
      ST_DONE: begin
        store_done = 1'b1;
        if (store_start) state_nxt = (beats_clamped == 6'd0) ? ST_DONE : ST_RUN;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      base_q    <= '0;
      pasid_q   <= '0;
      data_q    <= '0;
      beats_q   <= '0;
      aw_cnt    <= '0;
      w_cnt     <= '0;
      b_cnt     <= '0;
      store_err <= 1'b0;
    end else if (start_ok) begin
      base_q    <= store_start_addr;
      pasid_q   <= store_pasid;
      data_q    <= store_data;
      beats_q   <= beats_clamped;
      aw_cnt    <= '0;
      w_cnt     <= '0;
      b_cnt     <= '0;
      store_err <= 1'b0;
    end else begin
      if (aw_hs) aw_cnt <= aw_cnt + 6'd1;
      if (w_hs)  w_cnt  <= w_cnt + 6'd1;
      if (b_hit) begin
        b_cnt <= b_cnt + 6'd1;
        if (m_axi.bresp != RESP_OKAY) store_err <= 1'b1;
      end
    end
  end

  sort_store_beat_sel #(
    .DATA_WIDTH  (DATA_WIDTH),
    .STORE_WIDTH (STORE_WIDTH)
  ) u_beat_sel (
    .store_data (data_q),
    .beat_num   (beats_q),
    .w_cnt      (w_cnt),
    .wdata      (wdata_sel)
  );

  assign m_axi.awid     = '0;
  assign m_axi.awaddr   = base_q + (ADDR_WIDTH'(aw_cnt) * ADDR_WIDTH'(BEAT_BYTES));
  assign m_axi.awlen    = 8'd0;
  assign m_axi.awsize   = SIZE_128B;
  assign m_axi.awburst  = BURST_INCR;
  assign m_axi.awuser   = AWUSER_WIDTH'(pasid_q);
  assign m_axi.awcache  = CACHE_NB;
  assign m_axi.awlock   = 2'd0;
  assign m_axi.awprot   = 3'd0;
  assign m_axi.awqos    = 4'd0;
  assign m_axi.awregion = 4'd0;
  assign m_axi.wdata    = wdata_sel;
  assign m_axi.wstrb    = '1;
  assign m_axi.wlast    = 1'b1;
  assign m_axi.bready   = 1'b1;

endmodule

// File: tb/tb_sort_store.sv
// tb_sort_store: directed job sequence with random data, addresses and
// ready patterns, checked against a per-beat reference of the addresses,
// data slices, response accounting and done/error flags.
module tb_sort_store;

  logic          clk = 1'b0;
  logic          rst;
  logic          store_start;
  logic [63:0]   store_start_addr;
  logic [8:0]    store_pasid;
  logic [32767:0] store_data;
  logic [5:0]    store_beat_num;
  logic          store_done;
  logic          store_err;

  logic [32767:0] sd;
  int checks = 0;
  int errors = 0;

  sort_store_if m_axi ();

  sort_store dut (
    .clk              (clk),
    .rst              (rst),
    .store_start      (store_start),
    .store_start_addr (store_start_addr),
    .store_pasid      (store_pasid),
    .store_data       (store_data),
    .store_beat_num   (store_beat_num),
    .store_done       (store_done),
    .store_err        (store_err),
    .m_axi            (m_axi)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_w(input string tag, input logic [1023:0] obs, input logic [1023:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic fill_sd();
    for (int i = 0; i < 1024; i++) sd[i*32 +: 32] = $urandom();
  endtask

  // mode 0: always ready; 1: awready low 5 cycles, wready toggling; 2: random
  task automatic run_job(input logic [5:0] n_req, input logic [63:0] base,
                         input logic [8:0] pasid, input int mode, input int err_beat,
                         input int busy_cyc, input int rst_at_w);
    int n, aw_acc, w_acc, b_acc, cyc;
    logic err_exp, aw_hs, w_hs, b_drv;
    logic [1:0] resp;
    n = (n_req > 6'd32) ? 32 : int'(n_req);
    aw_acc = 0; w_acc = 0; b_acc = 0; cyc = 0; err_exp = 1'b0; resp = 2'b00;
    @(negedge clk);
    m_axi.bvalid     = 1'b0;
    store_start      = 1'b1;
    store_start_addr = base;
    store_pasid      = pasid;
    store_beat_num   = n_req;
    store_data       = sd;
    @(negedge clk);
    store_start = 1'b0;
    while (cyc < 3000) begin
      chk("done", {63'd0, store_done}, {63'd0, b_acc == n});
      chk("err", {63'd0, store_err}, {63'd0, err_exp});
      chk("awvalid", {63'd0, m_axi.awvalid}, {63'd0, aw_acc < n});
      chk("wvalid", {63'd0, m_axi.wvalid}, {63'd0, w_acc < n});
      if (b_acc == n) break;
      if (rst_at_w >= 0 && w_acc == rst_at_w) begin
        rst = 1'b1;
        m_axi.bvalid = 1'b0;
        @(negedge clk);
        chk("rst_awvalid", {63'd0, m_axi.awvalid}, 64'd0);
        chk("rst_wvalid", {63'd0, m_axi.wvalid}, 64'd0);
        chk("rst_done", {63'd0, store_done}, 64'd0);
        chk("rst_err", {63'd0, store_err}, 64'd0);
        rst = 1'b0;
        return;
      end
      if (m_axi.awvalid) begin
        chk("awaddr", m_axi.awaddr, base + 64'(aw_acc) * 64'd128);
        chk("awuser", {55'd0, m_axi.awuser}, {55'd0, pasid});
      end
      if (m_axi.wvalid)
        chk_w("wdata", m_axi.wdata, sd[(n-1-w_acc)*1024 +: 1024]);
      case (mode)
        0: begin m_axi.awready = 1'b1; m_axi.wready = 1'b1; end
        1: begin m_axi.awready = (cyc >= 5); m_axi.wready = ((cyc % 2) == 0); end
        default: begin
          m_axi.awready = 1'($urandom_range(0, 1));
          m_axi.wready  = 1'($urandom_range(0, 1));
        end
      endcase
      b_drv = (b_acc < aw_acc) && (b_acc < w_acc);
      resp  = (b_acc == err_beat) ? 2'b10 : 2'b00;
      m_axi.bvalid = b_drv;
      m_axi.bresp  = resp;
      if (cyc == busy_cyc) begin
        store_start      = 1'b1;
        store_beat_num   = 6'd7;
        store_start_addr = base ^ 64'hF000;
        store_data       = ~sd;
      end
      aw_hs = m_axi.awvalid && m_axi.awready;
      w_hs  = m_axi.wvalid && m_axi.wready;
      @(negedge clk);
      store_start  = 1'b0;
      m_axi.bvalid = 1'b0;
      if (aw_hs) aw_acc++;
      if (w_hs)  w_acc++;
      if (b_drv) begin
        b_acc++;
        if (resp != 2'b00) err_exp = 1'b1;
      end
      cyc++;
    end
    if (cyc >= 3000) chk("timeout", 64'(b_acc), 64'(n));
    chk("aw_count", 64'(aw_acc), 64'(n));
    chk("w_count", 64'(w_acc), 64'(n));
  endtask

  task automatic spurious_b(input logic exp_done);
    @(negedge clk);
    m_axi.bvalid = 1'b1;
    m_axi.bresp  = 2'b10;
    @(negedge clk);
    m_axi.bvalid = 1'b0;
    m_axi.bresp  = 2'b00;
    @(negedge clk);
    chk("spur_err", {63'd0, store_err}, 64'd0);
    chk("spur_done", {63'd0, store_done}, {63'd0, exp_done});
  endtask

  initial begin
    logic [63:0] rbase;
    rst = 1'b1;
    store_start = 1'b0; store_start_addr = '0; store_pasid = '0;
    store_data = '0; store_beat_num = '0; sd = '0;
    m_axi.awready = 1'b0; m_axi.wready = 1'b0;
    m_axi.bid = '0; m_axi.bresp = 2'b00; m_axi.bvalid = 1'b0;
    repeat (3) @(negedge clk);
    chk("reset_done", {63'd0, store_done}, 64'd0);
    chk("reset_err", {63'd0, store_err}, 64'd0);
    chk("reset_awvalid", {63'd0, m_axi.awvalid}, 64'd0);
    chk("reset_wvalid", {63'd0, m_axi.wvalid}, 64'd0);
    chk("reset_awaddr", m_axi.awaddr, 64'd0);
    chk("reset_awuser", {55'd0, m_axi.awuser}, 64'd0);
    chk("awlen", {56'd0, m_axi.awlen}, 64'd0);
    chk("awsize", {61'd0, m_axi.awsize}, 64'd7);
    chk("awburst", {62'd0, m_axi.awburst}, 64'd1);
    chk("awcache", {60'd0, m_axi.awcache}, 64'd3);
    chk("wstrb", {63'd0, &m_axi.wstrb}, 64'd1);
    chk("wlast", {63'd0, m_axi.wlast}, 64'd1);
    chk("bready", {63'd0, m_axi.bready}, 64'd1);
    rst = 1'b0;

    fill_sd();
    run_job(6'd4, 64'h1000_0000, 9'h05, 0, -1, -1, -1);
    run_job(6'd4, 64'h1000_0000, 9'h1A3, 1, -1, -1, -1);
    spurious_b(1'b1);

    fill_sd();
    run_job(6'd2, 64'h2000_0080, 9'h011, 0, 1, -1, -1);
    run_job(6'd1, 64'h2000_1000, 9'h012, 0, -1, -1, -1);

    run_job(6'd0, 64'h3000_0000, 9'h013, 0, -1, -1, -1);

    fill_sd();
    rbase = {$urandom(), $urandom()} & ~64'h7F;
    run_job(6'd32, rbase, 9'h0FF, 2, -1, -1, -1);
    fill_sd();
    run_job(6'd40, 64'h4000_0000, 9'h100, 0, -1, -1, -1);
    run_job(6'd4, 64'hFFFF_FFFF_FFFF_FF00, 9'h101, 0, -1, -1, -1);

    fill_sd();
    run_job(6'd4, 64'h5000_0000, 9'h102, 0, -1, 1, -1);

    run_job(6'd6, 64'h6000_0000, 9'h103, 1, -1, -1, 2);
    spurious_b(1'b0);

    for (int j = 0; j < 5; j++) begin
      fill_sd();
      rbase = {$urandom(), $urandom()} & ~64'h7F;
      run_job(6'($urandom_range(1, 32)), rbase, 9'($urandom()), 2,
              ($urandom_range(0, 1) == 1) ? int'($urandom_range(0, 7)) : -1, -1, -1);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
